glm_dot_modify: RTL and testbench

Scalar post-processing stage directly downstream of the GLM dot-product stage. Pops one 32-bit float dot result per sample from the dot FIFO and fetches that sample's label from label BRAM. Computes `scalar = (dot - label) * step_size` in float32 and pushes it to the scalar FIFO consumed by the model-update stage. Runs one sample per cycle when inputs are available and the output has room.

---
 rtl/glm_dot_modify.sv | 195 +++++++++++++++++++
 tb/tb_glm_dot_modify.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/glm_dot_modify.sv
// glm_dot_modify: float32 scalar = (dot - label) * step_size stage; the label subtract is enabled by GLM_MODIFY_LABEL_SUB_EN
module glm_dot_modify #(
  parameter int MEM_LATENCY = 2,
  parameter int SUB_LATENCY = 3,
  parameter int MUL_LATENCY = 3,
  parameter int HOLD_DEPTH = 4,
  parameter int NUM_REGS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_start,
  output logic         op_done,
  input  logic [31:0]  regs [NUM_REGS],
  input  logic [31:0]  fifo_dot_rdata,
  input  logic         fifo_dot_rvalid,
  input  logic         fifo_dot_empty,
  output logic         fifo_dot_re,
  input  logic [511:0] mem_labels_rdata,
  input  logic         mem_labels_rvalid,
  output logic         mem_labels_re,
  output logic [15:0]  mem_labels_raddr,
  output logic         fifo_scalar_we,
  output logic [31:0]  fifo_scalar_wdata,
  input  logic         fifo_scalar_full,
  input  logic         fifo_scalar_almostfull
);
`ifdef GLM_MODIFY_LABEL_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  localparam int AW = $clog2(HOLD_DEPTH);
  localparam logic [31:0] QNAN = 32'h7FC00000;
  function automatic logic [31:0] fadd(input logic [31:0] p, input logic [31:0] q);
    logic [31:0] a, b, r;
    logic [7:0] ea, eb, d;
    logic [26:0] x, y;
    logic [27:0] s;
    logic [9:0] e;
    logic up;
    a = p[30:0] >= q[30:0] ? p : q;
    b = p[30:0] >= q[30:0] ? q : p;
    ea = a[30:23] == 8'd0 ? 8'd1 : a[30:23];
    eb = b[30:23] == 8'd0 ? 8'd1 : b[30:23];
    x = {a[30:23] != 8'd0, a[22:0], 3'b000};
    y = {b[30:23] != 8'd0, b[22:0], 3'b000};
    d = ea - eb;
    y = d > 8'd26 ? {26'd0, |y} : (y >> d) | {26'd0, |(y & ~({27{1'b1}} << d))};
    s = a[31] == b[31] ? {1'b0, x} + {1'b0, y} : {1'b0, x} - {1'b0, y};
    e = {2'b00, ea};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end
    for (int i = 0; i < 26; i++)
      if (!s[26] && e > 10'd1) begin
        s = s << 1;
        e = e - 10'd1;
      end
    up = s[2] & (s[3] | s[1] | s[0]);
    // rounding carry ripples into the exponent field, covering subnormal->normal and overflow->inf
    r = {a[31], s[26] ? e[7:0] : 8'd0, s[25:3]} + {31'd0, up};
    if (e > 10'd254) r = {a[31], 8'hFF, 23'd0};
    if (s == 28'd0) r = {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'hFF) r = (a[22:0] != 23'd0 || (b[30:23] == 8'hFF && a[31] != b[31])) ? QNAN : a;
    return r;
  endfunction
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic sg, up;
    logic [47:0] m, lost;
    logic [31:0] r;
    int e, sh;
    sg = a[31] ^ b[31];
    m = {24'd0, a[30:23] != 8'd0, a[22:0]} * {24'd0, b[30:23] != 8'd0, b[22:0]};
    e = int'(a[30:23] == 8'd0 ? 8'd1 : a[30:23]) + int'(b[30:23] == 8'd0 ? 8'd1 : b[30:23]) - 126;
    for (int i = 0; i < 47; i++)
      if (!m[47] && m != 48'd0) begin
        m = m << 1;
        e = e - 1;
      end
    sh = 1 - e;
    if (e < 1) begin
      lost = sh > 47 ? m : m & ~({48{1'b1}} << sh);
      m = sh > 47 ? 48'd0 : m >> sh;
      m[0] = m[0] | (|lost);
      e = 1;
    end
    up = m[23] & (m[24] | (|m[22:0]));
    r = {sg, m[47] ? e[7:0] : 8'd0, m[46:24]} + {31'd0, up};
    if (e > 254) r = {sg, 8'hFF, 23'd0};
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) r = {sg, 31'd0};
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      r = ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
           a[30:0] == 31'd0 || b[30:0] == 31'd0) ? QNAN : {sg, 8'hFF, 23'd0};
    return r;
  endfunction
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [15:0] num, off, issued, written, inflight, wr_next;
  logic [31:0] step;
  logic [31:0] dot_buf [HOLD_DEPTH];
  logic [31:0] lab_buf [HOLD_DEPTH];
  logic [3:0] sel_buf [HOLD_DEPTH];
  logic [AW:0] dot_wp, dot_rp, lab_wp, lab_rp, sel_wp, sel_rp;
  logic [SUB_LATENCY-1:0] sub_v;
  logic [MUL_LATENCY-1:0] mul_v;
  logic [31:0] sub_d [SUB_LATENCY];
  logic [31:0] mul_d [MUL_LATENCY];
  logic iss, fire, unused;
  logic [31:0] dot_head, lab_head;
  assign inflight = issued - written;
  assign wr_next = written + {15'd0, fifo_scalar_we};
  assign iss = state == RUN && !fifo_dot_empty && !fifo_scalar_almostfull && issued < num && inflight < 16'(HOLD_DEPTH);
  assign dot_head = dot_buf[dot_rp[AW-1:0]];
  assign lab_head = lab_buf[lab_rp[AW-1:0]];
  assign fire = dot_wp != dot_rp && (lab_wp != lab_rp || !SUB);
  assign fifo_scalar_we = mul_v[MUL_LATENCY-1];
  assign fifo_scalar_wdata = mul_d[MUL_LATENCY-1];
  always_comb begin
    unused = MEM_LATENCY < 0;
    for (int i = 0; i < NUM_REGS; i++) unused = unused ^ (^regs[i]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_done <= 1'b0;
      fifo_dot_re <= 1'b0;
      mem_labels_re <= 1'b0;
      mem_labels_raddr <= 16'd0;
      {num, off, issued, written, step} <= '0;
      {dot_wp, dot_rp, lab_wp, lab_rp, sel_wp, sel_rp} <= '0;
      sub_v <= '0;
      mul_v <= '0;
      for (int i = 0; i < SUB_LATENCY; i++) sub_d[i] <= 32'd0;
      for (int i = 0; i < MUL_LATENCY; i++) mul_d[i] <= 32'd0;
    end else begin
      op_done <= 1'b0;
      fifo_dot_re <= iss;
      mem_labels_re <= iss && SUB;
      if (iss) begin
        mem_labels_raddr <= off + {4'd0, issued[15:4]};
        issued <= issued + 16'd1;
      end
      if (iss && SUB) begin
        sel_buf[sel_wp[AW-1:0]] <= issued[3:0];
        sel_wp <= sel_wp + 1'b1;
      end
      // stray returns after a reset arrive while idle and are dropped
      if (fifo_dot_rvalid && state != IDLE) begin
        dot_buf[dot_wp[AW-1:0]] <= fifo_dot_rdata;
        dot_wp <= dot_wp + 1'b1;
      end
      if (mem_labels_rvalid && state != IDLE && SUB) begin
        lab_buf[lab_wp[AW-1:0]] <= mem_labels_rdata[{sel_buf[sel_rp[AW-1:0]], 5'd0} +: 32];
        lab_wp <= lab_wp + 1'b1;
        sel_rp <= sel_rp + 1'b1;
      end
      if (fire) begin
        dot_rp <= dot_rp + 1'b1;
        if (SUB) lab_rp <= lab_rp + 1'b1;
      end
      sub_v[0] <= fire && SUB;
      sub_d[0] <= fadd(dot_head, lab_head ^ 32'h80000000);
      for (int i = 1; i < SUB_LATENCY; i++) begin
        sub_v[i] <= sub_v[i-1];
        sub_d[i] <= sub_d[i-1];
      end
      mul_v[0] <= SUB ? sub_v[SUB_LATENCY-1] : fire;
      mul_d[0] <= fmul(SUB ? sub_d[SUB_LATENCY-1] : dot_head, step);
      for (int i = 1; i < MUL_LATENCY; i++) begin
        mul_v[i] <= mul_v[i-1];
        mul_d[i] <= mul_d[i-1];
      end
      written <= wr_next;
      case (state)
        IDLE: if (op_start) begin
          num <= regs[3][15:0];
          off <= regs[4][15:0];
          step <= regs[5];
          issued <= 16'd0;
          written <= 16'd0;
          op_done <= regs[3][15:0] == 16'd0;
          state <= regs[3][15:0] == 16'd0 ? IDLE : RUN;
        end
        RUN: if (issued == num) state <= DRAIN;
        default: if (wr_next == num) begin
          op_done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
  assert property (@(posedge clk) disable iff (reset) fifo_scalar_we |-> !fifo_scalar_full)
    else $fatal(1, "scalar FIFO written while full");
endmodule

// File: tb/tb_glm_dot_modify.sv
// tb_glm_dot_modify: directed bench with FIFO/BRAM models around glm_dot_modify
module tb_glm_dot_modify;
  localparam int ML = 2;
  localparam logic [31:0] HALF = 32'h3F000000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, op_start, op_done;
  logic [31:0] regs [8];
  logic [31:0] dot_rdata, wdata;
  logic dot_rvalid, dot_empty, dot_re, mem_rvalid, mem_re, we, full, af;
  logic [511:0] mem_rdata;
  logic [15:0] raddr;
  int n_cmp, n_err, cyc, done_cnt, done_at, start_at, last_we, dot_re_cnt, mem_re_cnt, under;
  logic [31:0] dq[$], wq[$];
  logic [15:0] rq[$];
  logic [511:0] mem [16];
  logic lat_v [ML];
  logic [511:0] lat_d [ML];
  bit stall, toggle;
  glm_dot_modify #(.MEM_LATENCY(ML), .SUB_LATENCY(3), .MUL_LATENCY(3), .HOLD_DEPTH(4), .NUM_REGS(8)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_done(op_done), .regs(regs),
    .fifo_dot_rdata(dot_rdata), .fifo_dot_rvalid(dot_rvalid), .fifo_dot_empty(dot_empty), .fifo_dot_re(dot_re),
    .mem_labels_rdata(mem_rdata), .mem_labels_rvalid(mem_rvalid), .mem_labels_re(mem_re), .mem_labels_raddr(raddr),
    .fifo_scalar_we(we), .fifo_scalar_wdata(wdata), .fifo_scalar_full(full), .fifo_scalar_almostfull(af));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] i2f(int k);
    int p = 0;
    if (k == 0) return 32'd0;
    for (int i = 0; i < 24; i++) if ((k >> i) != 0) p = i;
    return {1'b0, 8'(127 + p), 23'((k << (23 - p)) & 32'h7FFFFF)};
  endfunction
  // integer difference/value times 0.5: exponent minus one
  function automatic logic [31:0] exp_of(int d, int l);
`ifdef GLM_MODIFY_LABEL_SUB_EN
    return i2f(d - l) - 32'h00800000;
`else
    return i2f(d + 0 * l) - 32'h00800000;
`endif
  endfunction
  function automatic logic [31:0] wr(int k);
    return k < wq.size() ? wq[k] : 32'hFFFFFFFF;
  endfunction
  task automatic fill_mem(int off);
    for (int j = 0; j < 16; j++)
      for (int w = 0; w < 16; w++) mem[(off + j) % 16][32*w +: 32] = i2f(16*j + w);
  endtask
  task automatic flush();
    dq.delete();
    for (int i = 0; i < ML; i++) lat_v[i] = 1'b0;
    dot_rvalid = 1'b0;
    mem_rvalid = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (we) begin wq.push_back(wdata); last_we = cyc; end
    if (op_done) begin done_cnt++; done_at = cyc; end
    if (mem_re) begin mem_re_cnt++; rq.push_back(raddr); end
    if (dot_re) begin dot_re_cnt++; if (dq.size() == 0) under++; end
    dot_rvalid = dot_re && dq.size() > 0;
    if (dot_rvalid) dot_rdata = dq.pop_front();
    mem_rvalid = lat_v[ML-1];
    mem_rdata = lat_d[ML-1];
    for (int i = ML - 1; i > 0; i--) begin lat_v[i] = lat_v[i-1]; lat_d[i] = lat_d[i-1]; end
    lat_v[0] = mem_re;
    lat_d[0] = mem[raddr[3:0]];
    dot_empty = dq.size() == 0 || (stall && $urandom_range(0, 3) == 0);
    if (toggle && cyc % 7 == 0) af = !af;
  endtask
  task automatic start_op(int num, int off, logic [31:0] step);
    regs[3] = num;
    regs[4] = off;
    regs[5] = step;
    wq.delete();
    rq.delete();
    {done_cnt, dot_re_cnt, mem_re_cnt, under} = '0;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    start_at = cyc;
    regs[3] = 32'd7;
    regs[5] = 32'hDEADBEEF;
  endtask
  task automatic run_op(string tag, int num, int off, logic [31:0] step, int budget);
    start_op(num, off, step);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    repeat (4) tick();
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_writes"}, wq.size(), num);
    check({tag, "_underflow"}, under, 0);
  endtask
  initial begin
    {n_cmp, n_err, cyc, last_we, done_at} = '0;
    for (int i = 0; i < 8; i++) regs[i] = 32'd0;
    {reset, op_start, full, af, stall, toggle} = '0;
    reset = 1'b1;
    dot_rdata = 32'd0;
    mem_rdata = '0;
    dot_empty = 1'b1;
    flush();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_op_done", op_done, 0);
    check("rst_dot_re", dot_re, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_we", we, 0);
    check("rst_raddr", raddr, 0);
    check("rst_wdata", wdata, 0);
    fill_mem(0);
    for (int k = 0; k < 16; k++) dq.push_back(i2f(k + 1));
    run_op("t1", 16, 0, HALF, 500);
    for (int k = 0; k < 16; k++) check($sformatf("t1_val%0d", k), wr(k), exp_of(k + 1, k));
    check("t1_done_after_we", done_at, last_we + 1);
    check("t1_dot_reads", dot_re_cnt, 16);
    fill_mem(5);
    for (int k = 0; k < 20; k++) dq.push_back(i2f(k + 1));
    run_op("t2", 20, 5, HALF, 500);
    for (int k = 0; k < 20; k++) check($sformatf("t2_val%0d", k), wr(k), exp_of(k + 1, k));
`ifdef GLM_MODIFY_LABEL_SUB_EN
    check("t2_raddr_cnt", rq.size(), 20);
    for (int k = 0; k < 20 && k < rq.size(); k++) check($sformatf("t2_raddr%0d", k), rq[k], k < 16 ? 5 : 6);
`else
    check("t2_no_mem_re", mem_re_cnt, 0);
`endif
    fill_mem(0);
    for (int k = 0; k < 100; k++) dq.push_back(i2f(2*k + 1));
    stall = 1'b1;
    toggle = 1'b1;
    run_op("t3", 100, 0, HALF, 5000);
    {stall, toggle, af} = '0;
    for (int k = 0; k < 100; k++) check($sformatf("t3_val%0d", k), wr(k), exp_of(2*k + 1, k));
    check("t3_done_after_we", done_at, last_we + 1);
    run_op("t4", 0, 0, HALF, 20);
    check("t4_done_lat", done_at, start_at);
    check("t4_dot_re", dot_re_cnt, 0);
    check("t4_mem_re", mem_re_cnt, 0);
    for (int k = 0; k < 32; k++) dq.push_back(i2f(k + 1));
    start_op(32, 0, HALF);
    for (int i = 0; i < 200 && dot_re_cnt < 5; i++) tick();
    check("t5_reached", dot_re_cnt, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_op_done", op_done, 0);
    check("t5_rst_dot_re", dot_re, 0);
    check("t5_rst_mem_re", mem_re, 0);
    check("t5_rst_we", we, 0);
    check("t5_rst_raddr", raddr, 0);
    check("t5_rst_wdata", wdata, 0);
    flush();
    wq.delete();
    repeat (20) tick();
    check("t5_quiet_writes", wq.size(), 0);
    for (int k = 0; k < 4; k++) dq.push_back(i2f(k + 1));
    run_op("t5b", 4, 0, HALF, 200);
    for (int k = 0; k < 4; k++) check($sformatf("t5b_val%0d", k), wr(k), exp_of(k + 1, k));
    dq.push_back(32'h40400000);
    run_op("t6", 1, 0, 32'h40000000, 100);
    check("t6_six", wr(0), 32'h40C00000);
`ifdef GLM_MODIFY_LABEL_SUB_EN
    check("t6_mem_re", mem_re_cnt, 1);
`else
    check("t6_mem_re", mem_re_cnt, 0);
`endif
    dq.push_back(32'h40400000);
    dq.push_back(32'h7FC00000);
    run_op("t7", 2, 0, 32'hC0000000, 100);
    check("t7_neg6", wr(0), 32'hC0C00000);
    check("t7_nan", {31'd0, wr(1)[30:23] == 8'hFF && wr(1)[22:0] != 23'd0}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
